gray_seq_ctrl: RTL

GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

---
 rtl/gray_seq_pkg.sv | 11 +
 rtl/gray_seq_ctrl_bin2gray.sv | 10 +
 rtl/gray_seq_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/gray_seq_pkg.sv
// Shared constants for the Gray-code sequencer.
// The state encoding and default width live here so the RTL and its users agree on them.
package gray_seq_pkg;
  localparam int DEF_NUM_PIN = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;
endpackage

// File: rtl/gray_seq_ctrl_bin2gray.sv
// Binary to reflected-Gray converter.
// Purely combinational; no handshake of its own.
module Bin2Gray #(
  parameter int NUM_PIN = 3
) (
  input  logic [NUM_PIN:0] bin,
  output logic [NUM_PIN:0] gray
);
  assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/gray_seq_ctrl.sv
// Gray-code sequencer: counts from a loadable start value to LIMIT, offering each value as registered Gray code.
// A new value appears the cycle after each handshake; DONE pulses for one cycle after the terminal handshake.
// GRAY_READY low freezes the offer; defining GRAY_SEQ_DOWN_EN adds a DIR input for counting down.
module gray_seq_ctrl
  import gray_seq_pkg::*;
#(
  parameter int NUM_PIN = DEF_NUM_PIN
) (
  input  logic             CLK,
  input  logic             RST_N,
`ifdef GRAY_SEQ_DOWN_EN
  input  logic             DIR,
`endif
  input  logic             START,
  input  logic             STOP,
  input  logic             LOAD,
  input  logic [NUM_PIN:0] LOAD_BIN,
  input  logic [NUM_PIN:0] LIMIT,
  input  logic             GRAY_READY,
  output logic [NUM_PIN:0] GRAY_OUT,
  output logic             GRAY_VALID,
  output logic [NUM_PIN:0] BIN_OUT,
  output logic             BUSY,
  output logic             DONE
);
  localparam logic [NUM_PIN:0] ONE = {{NUM_PIN{1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [NUM_PIN:0] count, count_nxt;
  logic [NUM_PIN:0] gray_q, gray_nxt;
  logic             hs;
  logic             at_limit;

  assign hs       = (state == RUN) && GRAY_READY;
  assign at_limit = (count == LIMIT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // The terminal handshake wins over a coincident STOP so the run still reports DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (START) state_nxt = RUN;
      RUN: begin
        if (hs && at_limit) state_nxt = FIN;
        else if (STOP)      state_nxt = IDLE;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    GRAY_VALID = (state == RUN);
    BUSY       = (state == RUN);
    DONE       = (state == FIN);
  end

  always_comb begin
    count_nxt = count;
    if (state == IDLE && LOAD) begin
      count_nxt = LOAD_BIN;
    end else if (hs && !at_limit) begin
`ifdef GRAY_SEQ_DOWN_EN
      count_nxt = DIR ? (count - ONE) : (count + ONE);
`else
      count_nxt = count + ONE;
`endif
    end
  end

  // Gray is computed from the next count so GRAY_OUT is registered yet always matches BIN_OUT.
  Bin2Gray #(.NUM_PIN(NUM_PIN)) u_bin2gray (
    .bin  (count_nxt),
    .gray (gray_nxt)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count  <= '0;
      gray_q <= '0;
    end else begin
      count  <= count_nxt;
      gray_q <= gray_nxt;
    end
  end

  assign BIN_OUT  = count;
  assign GRAY_OUT = gray_q;
endmodule
